// File: rtl/arbitro_uart_if.sv
// Custom-instruction handshake between the CPU slot and the sensor arbiter.
// The CPU side drives the operand and start; the arbiter returns result and a done pulse.
interface arbitro_uart_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;

  modport master (output clk_en, start, dataa, input result, done);
  modport slave  (input clk_en, start, dataa, output result, done);
endinterface

// File: rtl/arbitro_uart.sv
// Sensor-polling arbiter as a multi-cycle custom instruction: sends a 16-bit request frame on tx,
// awaits a 16-bit response on rx, classifies it; done pulses 2 cycles after a valid stop bit, clk_en low freezes everything.
module arbitro_uart #(
  parameter int BAUD_DIV = 1,
  parameter int TIMEOUT  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  arbitro_uart_if.slave     ci,
  input  logic              rx,
  output logic              tx,
  output logic              saidaDiv,
  output logic [3:0]        stateReceptor,
  output logic [3:0]        stateVerificador,
  output logic [3:0]        stateEnvio,
  output logic [15:0]       pacotes
);

  localparam int DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [3:0] V_IDLE  = 4'd0;
  localparam logic [3:0] V_LOAD  = 4'd1;
  localparam logic [3:0] V_SEND  = 4'd2;
  localparam logic [3:0] V_WAIT  = 4'd4;
  localparam logic [3:0] V_CHECK = 4'd5;
  localparam logic [3:0] V_DONE  = 4'd6;

  localparam logic [3:0] T_IDLE  = 4'd0;
  localparam logic [3:0] T_START = 4'd1;
  localparam logic [3:0] T_DATA  = 4'd2;
  localparam logic [3:0] T_STOP  = 4'd3;

  localparam logic [3:0] R_IDLE  = 4'd0;
  localparam logic [3:0] R_DATA  = 4'd1;
  localparam logic [3:0] R_STOP  = 4'd2;

  logic [DW-1:0] div_cnt;
  logic          tick_raw, tick;
  logic [3:0]    v_state, t_state, r_state;
  logic [15:0]   req, t_sh, r_sh, pac_q, status;
  logic [3:0]    t_cnt, r_cnt;
  logic [TW-1:0] to_cnt;
  logic [31:0]   result_q;
  logic          tx_q, tx_fin, rx_vld;

  assign tick_raw = (div_cnt == DIV_LAST);
  assign tick     = ci.clk_en & tick_raw;
  assign saidaDiv = tick_raw & ~reset;

  assign tx_fin = (t_state == T_STOP) & tick;
  assign rx_vld = (v_state == V_WAIT) & (r_state == R_STOP) & tick & rx;

  assign tx               = tx_q;
  assign pacotes          = pac_q;
  assign ci.result        = result_q;
  assign ci.done          = (v_state == V_DONE) & ci.clk_en;
  assign stateVerificador = v_state;
  assign stateEnvio       = t_state;
  assign stateReceptor    = r_state;

  always_ff @(posedge clk) begin
    if (reset)
      div_cnt <= '0;
    else if (ci.clk_en)
      div_cnt <= tick_raw ? '0 : div_cnt + 1'b1;
  end

  always_comb begin
    status = 16'h0004;
    case (pac_q[15:8])
      8'h32:   status = 16'h0001;
      8'h37:   status = 16'h0002;
      default: status = 16'h0004;
    endcase
  end

  // Verifier: owns the instruction handshake and sequences the two serial engines.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_state  <= V_IDLE;
      req      <= '0;
      to_cnt   <= '0;
      result_q <= '0;
    end else if (ci.clk_en) begin
      case (v_state)
        V_IDLE: if (ci.start) begin
          req     <= ci.dataa[15:0];
          v_state <= V_LOAD;
        end
        V_LOAD: v_state <= V_SEND;
        V_SEND: if (tx_fin) begin
          to_cnt  <= '0;
          v_state <= V_WAIT;
        end
        V_WAIT: begin
          if (rx_vld)
            v_state <= V_CHECK;
          else if (tick) begin
            if (to_cnt == TO_LAST) begin
              result_q <= {16'h0003, 16'h0000};
              v_state  <= V_DONE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        V_CHECK: begin
          result_q <= {status, pac_q};
          v_state  <= V_DONE;
        end
        V_DONE:  v_state <= V_IDLE;
        default: v_state <= V_IDLE;
      endcase
    end
  end

  // Transmitter: tx only moves on ticks; the STOP tick drives the stop bit and ends the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_state <= T_IDLE;
      tx_q    <= 1'b1;
      t_sh    <= '0;
      t_cnt   <= '0;
    end else if (ci.clk_en) begin
      case (t_state)
        T_IDLE: begin
          tx_q <= 1'b1;
          if (v_state == V_LOAD) begin
            t_sh    <= req;
            t_state <= T_START;
          end
        end
        T_START: if (tick) begin
          tx_q    <= 1'b0;
          t_cnt   <= '0;
          t_state <= T_DATA;
        end
        T_DATA: if (tick) begin
          tx_q  <= t_sh[0];
          t_sh  <= {1'b0, t_sh[15:1]};
          t_cnt <= t_cnt + 1'b1;
          if (t_cnt == 4'd15)
            t_state <= T_STOP;
        end
        T_STOP: if (tick) begin
          tx_q    <= 1'b1;
          t_state <= T_IDLE;
        end
        default: t_state <= T_IDLE;
      endcase
    end
  end

  // Receiver: held idle outside WAIT_RESP so line noise never starts a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      pac_q   <= '0;
    end else if (ci.clk_en) begin
      if (v_state != V_WAIT) begin
        r_state <= R_IDLE;
      end else begin
        case (r_state)
          R_IDLE: if (tick && !rx) begin
            r_cnt   <= '0;
            r_state <= R_DATA;
          end
          R_DATA: if (tick) begin
            r_sh  <= {rx, r_sh[15:1]};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == 4'd15)
              r_state <= R_STOP;
          end
          R_STOP: if (tick) begin
            if (rx)
              pac_q <= r_sh;
            r_state <= R_IDLE;
          end
          default: r_state <= R_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arbitro_uart.sv
// Randomized bench for arbitro_uart against a frame-level reference model.
module tb_arbitro_uart;
  localparam int BAUD_DIV = 1;
  localparam int TIMEOUT  = 1000;
  localparam int FRAME    = 18;

  logic        clk = 1'b0;
  logic        reset, rx, tx, saidaDiv;
  logic [3:0]  st_r, st_v, st_e;
  logic [15:0] pacotes;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t_wait = 0;
  logic [15:0] exp_pac;

  arbitro_uart_if ci();

  arbitro_uart #(.BAUD_DIV(BAUD_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ci(ci), .rx(rx), .tx(tx), .saidaDiv(saidaDiv),
    .stateReceptor(st_r), .stateVerificador(st_v), .stateEnvio(st_e), .pacotes(pacotes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response classification straight from the code table.
  function automatic logic [31:0] model(input logic [15:0] resp, input bit timed_out);
    if (timed_out) return 32'h0003_0000;
    case (resp[15:8])
      8'h32:   return {16'h0001, resp};
      8'h37:   return {16'h0002, resp};
      default: return {16'h0004, resp};
    endcase
  endfunction

  task automatic send_cmd(input logic [31:0] d, input bit hold, input logic [31:0] after);
    @(negedge clk);
    ci.dataa = d;
    ci.start = 1'b1;
    @(negedge clk);
    chk("latch_state", st_v, 32'd1);
    if (!hold) ci.start = 1'b0;
    ci.dataa = after;
  endtask

  task automatic expect_tx(input logic [15:0] req, input string tag);
    logic [15:0] w;
    bit seen = 0;
    bit rx_ok = 1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (st_r != 4'd0) rx_ok = 0;
      if (tx === 1'b0) seen = 1;
      rx = 1'($urandom);
    end
    chk({tag, "_start"}, 32'(seen), 32'd1);
    w = '0;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      w[b] = tx;
      if (st_r != 4'd0) rx_ok = 0;
      rx = 1'($urandom);
    end
    chk({tag, "_data"}, 32'(w), 32'(req));
    @(negedge clk);
    if (st_r != 4'd0) rx_ok = 0;
    chk({tag, "_stop"}, 32'(tx), 32'd1);
    chk({tag, "_rx_ignored"}, 32'(rx_ok), 32'd1);
    chk({tag, "_wait_resp"}, 32'(st_v), 32'd4);
    rx = 1'b1;
    t_wait = cyc;
  endtask

  task automatic send_frame(input logic [15:0] w, input bit good);
    rx = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 16; b++) begin
      rx = w[b];
      @(negedge clk);
    end
    rx = good;
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_done(input logic [31:0] exp, input int lat, input string tag);
    bit seen = 0;
    for (int i = 0; i < TIMEOUT + 100 && !seen; i++) begin
      @(negedge clk);
      if (ci.done === 1'b1) seen = 1;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_result"}, ci.result, exp);
    chk({tag, "_latency"}, 32'(cyc - t_wait), 32'(lat));
    chk({tag, "_pacotes"}, 32'(pacotes), 32'(exp_pac));
    @(negedge clk);
    chk({tag, "_one_pulse"}, 32'(ci.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] req, resp;
    bit bad, seen, any_done, rx_ok;
    reset = 1'b1; rx = 1'b1;
    ci.clk_en = 1'b1; ci.start = 1'b0; ci.dataa = '0;
    exp_pac = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_done", 32'(ci.done), 32'd0);
    chk("rst_result", ci.result, 32'd0);
    chk("rst_states", {20'd0, st_r, st_v, st_e}, 32'd0);
    chk("rst_pacotes", 32'(pacotes), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("tick_const", 32'(saidaDiv), 32'd1);

    rx_ok = 1;
    for (int i = 0; i < 20; i++) begin
      rx = 1'($urandom);
      @(negedge clk);
      if (st_r != 4'd0) rx_ok = 0;
    end
    chk("idle_rx_ignored", 32'(rx_ok), 32'd1);
    rx = 1'b1;

    // Held start with dataa changed after the latch; clk_en pause in WAIT_RESP.
    send_cmd(32'h0000_0005, 1'b1, 32'h0000_0002);
    expect_tx(16'h0005, "tx5");
    ci.clk_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("freeze_state", 32'(st_v), 32'd4);
    chk("freeze_tx", 32'(tx), 32'd1);
    ci.clk_en = 1'b1;
    send_frame(16'h3205, 1'b1);
    exp_pac = 16'h3205;
    wait_done(model(16'h3205, 0), FRAME + 1 + 5, "d3205");
    chk("poll_idle", 32'(st_v), 32'd0);
    @(negedge clk);
    chk("poll_next", 32'(st_v), 32'd1);
    ci.start = 1'b0;
    expect_tx(16'h0002, "tx2");
    chk("result_hold", ci.result, 32'h0001_3205);

    // clk_en drops while in DONE: done masked, completes once enabled.
    send_frame(16'h3700, 1'b1);
    exp_pac = 16'h3700;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (st_v == 4'd6) seen = 1;
    end
    chk("done_state", 32'(seen), 32'd1);
    ci.clk_en = 1'b0;
    #1 chk("done_masked", 32'(ci.done), 32'd0);
    repeat (3) @(negedge clk);
    chk("done_held", 32'(st_v), 32'd6);
    ci.clk_en = 1'b1;
    #1 chk("done_resume", 32'(ci.done), 32'd1);
    chk("d3700_result", ci.result, model(16'h3700, 0));
    @(negedge clk);
    chk("d3700_idle", 32'(st_v), 32'd0);

    // Framing error, then silence until timeout.
    send_cmd(32'h0000_1234, 1'b0, $urandom);
    expect_tx(16'h1234, "tx1234");
    send_frame(16'h3299, 1'b0);
    wait_done(model(16'h0, 1), TIMEOUT, "timeout");

    // Reset in the middle of a request frame.
    send_cmd(32'h0000_A5A5, 1'b0, $urandom);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_states", {20'd0, st_r, st_v, st_e}, 32'd0);
    any_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ci.done !== 1'b0 || tx !== 1'b1) any_done = 1;
    end
    chk("abort_quiet", 32'(any_done), 32'd0);
    exp_pac = 16'h0;

    for (int k = 0; k < 8; k++) begin
      req = 16'($urandom);
      resp = 16'($urandom);
      case ($urandom_range(0, 2))
        0: resp[15:8] = 8'h32;
        1: resp[15:8] = 8'h37;
        default: ;
      endcase
      bad = ($urandom_range(0, 4) == 0);
      send_cmd({16'($urandom), req}, 1'b0, $urandom);
      expect_tx(req, "rnd_tx");
      send_frame(resp, !bad);
      if (!bad) exp_pac = resp;
      wait_done(model(resp, bad), bad ? TIMEOUT : FRAME + 1, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
